// File: rtl/sram_arbiter_pkg.sv
// b16_mem_pkg: shared encodings for the two-port SRAM arbiter.
package b16_mem_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_DONE} state_t;
    typedef enum logic {PORT_C = 1'b0, PORT_U = 1'b1} port_t;
    typedef enum logic [1:0] {OP_NONE, OP_RD, OP_WR} op_t;
    localparam int DEF_WAIT_STATES = 3;
    function automatic op_t decode_op(input logic r, input logic [1:0] w);
        return (w != 2'b00) ? OP_WR : r ? OP_RD : OP_NONE;
    endfunction
endpackage

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: requester handshakes (ports c/u) plus SRAM pin bundle.
interface sram_arbiter_if #(parameter int AW = 15);
    logic          c_req, c_r, c_ack, u_req, u_r, u_ack, grant_u;
    logic [15:0]   c_addr, c_wdata, c_rdata, u_addr, u_wdata, u_rdata;
    logic [1:0]    c_w, u_w;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_o, sram_dq_i;
    logic          sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
    modport master (
        output c_req, c_addr, c_r, c_w, c_wdata, u_req, u_addr, u_r, u_w, u_wdata, sram_dq_i,
        input  c_rdata, c_ack, u_rdata, u_ack, grant_u, sram_addr, sram_dq_o, sram_dq_oe,
               sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
    );
    modport slave (
        input  c_req, c_addr, c_r, c_w, c_wdata, u_req, u_addr, u_r, u_w, u_wdata, sram_dq_i,
        output c_rdata, c_ack, u_rdata, u_ack, grant_u, sram_addr, sram_dq_o, sram_dq_oe,
               sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
    );
endinterface

// File: rtl/sram_arbiter_pick.sv
// sram_arb_pick: grant select; fixed u-priority, or round-robin when ARB_RR_EN is defined.
module sram_arb_pick (
`ifdef ARB_RR_EN
    input  logic clk,
    input  logic reset,
    input  logic take,
`endif
    input  logic c_req,
    input  logic u_req,
    output logic any,
    output logic pick_u
);
    assign any = c_req | u_req;
`ifdef ARB_RR_EN
    logic last_u;
    // History only moves on contested picks, so each tie alternates the winner
    always_ff @(posedge clk or posedge reset)
        if (reset) last_u <= 1'b0;
        else if (take && c_req && u_req) last_u <= pick_u;
    assign pick_u = (c_req && u_req) ? ~last_u : u_req;
`else
    assign pick_u = u_req;
`endif
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: sequences c/u accesses to the async SRAM (IDLE/SETUP/ACCESS/DONE), registered strobes.
// Optional round-robin arbitration with ARB_RR_EN; default is fixed u-over-c priority.
module sram_arbiter
    import b16_mem_pkg::*;
#(
    parameter int WAIT_STATES = DEF_WAIT_STATES,
    parameter int AW = 15
) (
    input logic        clk,
    input logic        reset,
    sram_arbiter_if.slave bus
);
    state_t        state, state_n;
    op_t           op, op_n, req_op;
    logic [3:0]    cnt, cnt_n;
    logic [1:0]    wbe, wbe_n;
    logic [AW-1:0] addr;
    logic [15:0]   wdata, c_rdata, u_rdata;
    logic          grant_u, grant_n, any, pick_u, load, act;
    logic          c_ack, u_ack, ce_n, oe_n, we_n, ub_n, lb_n, dq_oe;

    assign load = (state == ST_IDLE) && any;

    sram_arb_pick u_pick (
`ifdef ARB_RR_EN
        .clk(clk), .reset(reset), .take(load),
`endif
        .c_req(bus.c_req), .u_req(bus.u_req), .any(any), .pick_u(pick_u)
    );

    assign req_op  = decode_op(pick_u ? bus.u_r : bus.c_r, pick_u ? bus.u_w : bus.c_w);
    assign op_n    = load ? req_op : op;
    assign wbe_n   = load ? (pick_u ? bus.u_w : bus.c_w) : wbe;
    assign grant_n = load ? pick_u : grant_u;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            ST_IDLE:   state_n = !any ? ST_IDLE : (req_op == OP_NONE) ? ST_DONE : ST_SETUP;
            ST_SETUP:  begin state_n = ST_ACCESS; cnt_n = 4'd0; end
            ST_ACCESS: begin
                state_n = (cnt == 4'(WAIT_STATES - 1)) ? ST_DONE : ST_ACCESS;
                cnt_n   = (cnt == 4'(WAIT_STATES - 1)) ? 4'd0 : cnt + 4'd1;
            end
            ST_DONE:   state_n = ST_IDLE;
        endcase
    end

    // Strobes are computed for the upcoming state so every pin comes straight off a flop
    assign act = (state_n != ST_IDLE) && (op_n != OP_NONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE; cnt <= 4'd0; op <= OP_NONE; wbe <= 2'b00;
            addr <= '0; wdata <= 16'h0; grant_u <= 1'b0;
            c_rdata <= 16'h0; u_rdata <= 16'h0; c_ack <= 1'b0; u_ack <= 1'b0;
            ce_n <= 1'b1; oe_n <= 1'b1; we_n <= 1'b1; ub_n <= 1'b1; lb_n <= 1'b1; dq_oe <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            op      <= op_n;
            wbe     <= wbe_n;
            grant_u <= grant_n;
            if (load) begin
                addr  <= pick_u ? bus.u_addr[AW:1] : bus.c_addr[AW:1];
                wdata <= pick_u ? bus.u_wdata : bus.c_wdata;
            end
            if (state == ST_ACCESS && state_n == ST_DONE && op == OP_RD) begin
                if (grant_u) u_rdata <= bus.sram_dq_i;
                else c_rdata <= bus.sram_dq_i;
            end
            c_ack <= (state_n == ST_DONE) && !grant_n;
            u_ack <= (state_n == ST_DONE) && grant_n;
            ce_n  <= !act;
            oe_n  <= !(act && op_n == OP_RD);
            we_n  <= !(state_n == ST_ACCESS && op_n == OP_WR);
            ub_n  <= !(act && (op_n == OP_RD || (op_n == OP_WR && wbe_n[1])));
            lb_n  <= !(act && (op_n == OP_RD || (op_n == OP_WR && wbe_n[0])));
            dq_oe <= act && op_n == OP_WR;
        end
    end

    assign bus.c_rdata    = c_rdata;
    assign bus.u_rdata    = u_rdata;
    assign bus.c_ack      = c_ack;
    assign bus.u_ack      = u_ack;
    assign bus.grant_u    = grant_u;
    assign bus.sram_addr  = addr;
    assign bus.sram_dq_o  = wdata;
    assign bus.sram_dq_oe = dq_oe;
    assign bus.sram_ce_n  = ce_n;
    assign bus.sram_oe_n  = oe_n;
    assign bus.sram_we_n  = we_n;
    assign bus.sram_ub_n  = ub_n;
    assign bus.sram_lb_n  = lb_n;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed checks of sram_arbiter (WAIT_STATES=3) against a 1-cycle-read SRAM model.
module tb_sram_arbiter;
    import b16_mem_pkg::*;
    logic clk, reset;
    int   errors = 0, checks = 0;
    int   lat, we_cnt, cu, cc;
    logic ce_lo, oe_lo, ub_lo, lb_lo, dqoe_hi, other_ack, ack_seen;
    logic [15:0] rd;
    logic [14:0] addr_seen;
    logic [15:0] mem [0:32767];

    sram_arbiter_if #(.AW(15)) bus ();
    sram_arbiter #(.WAIT_STATES(3), .AW(15)) dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!bus.sram_ce_n && !bus.sram_we_n && bus.sram_dq_oe) begin
            if (!bus.sram_ub_n) mem[bus.sram_addr][15:8] <= bus.sram_dq_o[15:8];
            if (!bus.sram_lb_n) mem[bus.sram_addr][7:0] <= bus.sram_dq_o[7:0];
        end
        bus.sram_dq_i <= mem[bus.sram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic xact(input bit pu, input logic [15:0] a, input logic r, input logic [1:0] w,
                        input logic [15:0] d);
        @(negedge clk);
        if (pu) begin bus.u_req = 1; bus.u_addr = a; bus.u_r = r; bus.u_w = w; bus.u_wdata = d; end
        else    begin bus.c_req = 1; bus.c_addr = a; bus.c_r = r; bus.c_w = w; bus.c_wdata = d; end
        lat = 0; we_cnt = 0; rd = 16'h0; addr_seen = 15'h0;
        {ce_lo, oe_lo, ub_lo, lb_lo, dqoe_hi, other_ack} = 6'b0;
        for (int i = 2; i <= 20 && lat == 0; i++) begin
            @(negedge clk);
            if (!bus.sram_we_n) we_cnt++;
            if (!bus.sram_ce_n) begin ce_lo = 1; addr_seen = bus.sram_addr; end
            if (!bus.sram_oe_n) oe_lo = 1;
            if (!bus.sram_ub_n) ub_lo = 1;
            if (!bus.sram_lb_n) lb_lo = 1;
            if (bus.sram_dq_oe) dqoe_hi = 1;
            if (pu ? bus.c_ack : bus.u_ack) other_ack = 1;
            if (pu ? bus.u_ack : bus.c_ack) begin lat = i; rd = pu ? bus.u_rdata : bus.c_rdata; end
        end
        bus.c_req = 0; bus.u_req = 0;
    endtask

    task automatic pair(input int exp_u, input int exp_c, input string tag);
        @(negedge clk);
        bus.c_req = 1; bus.c_addr = 16'h4002; bus.c_r = 1; bus.c_w = 2'b00;
        bus.u_req = 1; bus.u_addr = 16'h4002; bus.u_r = 1; bus.u_w = 2'b00;
        cu = 0; cc = 0;
        for (int i = 2; i <= 30 && (cu == 0 || cc == 0); i++) begin
            @(negedge clk);
            if (bus.u_ack && cu == 0) begin cu = i; bus.u_req = 0; end
            if (bus.c_ack && cc == 0) begin cc = i; bus.c_req = 0; end
        end
        bus.c_req = 0; bus.u_req = 0;
        check({tag, "_u_ack_cycle"}, cu, exp_u);
        check({tag, "_c_ack_cycle"}, cc, exp_c);
    endtask

    initial begin
        reset = 1;
        {bus.c_req, bus.c_r, bus.u_req, bus.u_r} = 4'b0;
        {bus.c_w, bus.u_w} = 4'b0;
        {bus.c_addr, bus.c_wdata, bus.u_addr, bus.u_wdata} = 64'h0;
        repeat (2) @(negedge clk);
        check("rst_strobes", {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_ub_n, bus.sram_lb_n}, 5'b11111);
        check("rst_dq_oe", bus.sram_dq_oe, 0);
        check("rst_acks", {bus.c_ack, bus.u_ack, bus.grant_u}, 3'b000);
        check("rst_rdata", {bus.c_rdata, bus.u_rdata}, 32'h0);
        check("rst_addr", bus.sram_addr, 15'h0);
        reset = 0;

        xact(0, 16'h4002, 0, 2'b11, 16'hBEEF);
        check("wr_latency", lat, 6);
        check("wr_we_cycles", we_cnt, 3);
        check("wr_addr", addr_seen, 15'h2001);
        check("wr_dq_oe", dqoe_hi, 1);
        check("wr_oe_n", oe_lo, 0);
        check("wr_u_ack", other_ack, 0);

        xact(0, 16'h4002, 1, 2'b00, 16'h0000);
        check("rd_latency", lat, 6);
        check("rd_data", rd, 16'hBEEF);
        check("rd_oe_n", oe_lo, 1);
        check("rd_we", we_cnt, 0);
        check("rd_u_ack", other_ack, 0);
        check("rd_grant", bus.grant_u, 0);

        xact(0, 16'h4002, 0, 2'b10, 16'h12AB);
        check("bw_ub", ub_lo, 1);
        check("bw_lb", lb_lo, 0);
        xact(0, 16'h4002, 1, 2'b00, 16'h0000);
        check("bw_readback", rd, 16'h12EF);

        xact(1, 16'h4002, 1, 2'b00, 16'h0000);
        check("u_rd_latency", lat, 6);
        check("u_rd_data", rd, 16'h12EF);
        check("u_grant", bus.grant_u, 1);
        check("u_c_ack", other_ack, 0);

        pair(6, 12, "pair1");
`ifdef ARB_RR_EN
        pair(12, 6, "pair2");
`else
        pair(6, 12, "pair2");
`endif

        @(negedge clk);
        bus.c_req = 1; bus.c_addr = 16'h0010; bus.c_r = 0; bus.c_w = 2'b11; bus.c_wdata = 16'h1234;
        repeat (2) @(negedge clk);
        check("rst_mid_we_before", bus.sram_we_n, 0);
        #1 reset = 1;
        #1;
        check("rst_mid_we_n", bus.sram_we_n, 1);
        check("rst_mid_ce_n", bus.sram_ce_n, 1);
        check("rst_mid_dq_oe", bus.sram_dq_oe, 0);
        bus.c_req = 0;
        @(negedge clk);
        reset = 0;
        check("rst_mid_state", 32'(dut.state), 32'(ST_IDLE));
        ack_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.c_ack || bus.u_ack) ack_seen = 1;
        end
        check("rst_mid_no_ack", ack_seen, 0);

        xact(1, 16'h0000, 0, 2'b00, 16'h0000);
        check("nop_latency", lat, 2);
        check("nop_ce_n", ce_lo, 0);
        check("nop_c_ack", other_ack, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
